// File: rtl/traffic_pkg.sv
// Shared phase codes and lamp bit positions for the intersection controller and the LCD stage.
package traffic_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned LED_W   = 7;

  typedef enum logic [STATE_W-1:0] {
    AG   = 3'd0,
    AY   = 3'd1,
    ACLR = 3'd2,
    BG   = 3'd3,
    BY   = 3'd4,
    BCLR = 3'd5
  } phase_e;

  localparam int unsigned LED_A_RED   = 6;
  localparam int unsigned LED_A_YEL   = 5;
  localparam int unsigned LED_A_GRN   = 4;
  localparam int unsigned LED_B_RED   = 3;
  localparam int unsigned LED_B_YEL   = 2;
  localparam int unsigned LED_B_GRN   = 1;
  localparam int unsigned LED_ALL_RED = 0;

endpackage

// File: rtl/tl_phase_counter.sv
// Phase seconds counter: loads a phase duration, counts down on each 1 Hz tick,
// and flags the tick that ends the phase.
module tl_phase_counter #(
  parameter int unsigned            CNT_W   = 6,
  parameter logic [CNT_W-1:0]       RST_VAL = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tick,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_done_c
);

  logic [CNT_W-1:0] r_cnt;

  // Load has priority so an illegal-state recovery reloads even without a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_tick) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_done_c = i_tick && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer with green extension and per-road countdowns.
// Define ALL_RED_EN to insert T_AR-second all-red clearance phases between greens.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned T_AG = 30,
  parameter int unsigned T_AY = 5,
  parameter int unsigned T_BG = 20,
  parameter int unsigned T_BY = 5,
  parameter int unsigned T_AR = 2
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               tick_1hz,
  input  logic               AS,
  input  logic               BS,
  output logic [STATE_W-1:0] state,
  output logic [LED_W-1:0]   led,
  output logic [CNT_W-1:0]   A_time,
  output logic [CNT_W-1:0]   B_time
);

`ifdef ALL_RED_EN
  localparam int unsigned C_CLR = T_AR;
`else
  localparam int unsigned C_CLR = 0;
`endif

  localparam logic [CNT_W-1:0] D_AG = CNT_W'(T_AG);
  localparam logic [CNT_W-1:0] D_AY = CNT_W'(T_AY);
  localparam logic [CNT_W-1:0] D_BG = CNT_W'(T_BG);
  localparam logic [CNT_W-1:0] D_BY = CNT_W'(T_BY);

  // Durations must fit the 6-bit countdowns, including the worst-case summed offsets.
  if (T_AG < 1 || T_AY < 1 || T_BG < 1 || T_BY < 1 || T_AR < 1) begin : g_bad_min
    $error("traffic_phase_ctrl: all durations must be >= 1");
  end
  if ((T_AG + T_AY + 2 * T_AR) > 63 || (T_BG + T_BY + 2 * T_AR) > 63) begin : g_bad_width
    $error("traffic_phase_ctrl: durations overflow 6-bit countdown");
  end

  phase_e           r_state;
  phase_e           w_next_state;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_cnt;
  logic             w_done;

  tl_phase_counter #(
    .CNT_W   (CNT_W),
    .RST_VAL (D_AG)
  ) u_cnt (
    .clk        (CLK),
    .rst_n      (RSTn),
    .i_tick     (tick_1hz),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_cnt      (w_cnt),
    .o_done_c   (w_done)
  );

  // Next phase and reload value; sensors matter only on the ending tick.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = D_AG;
    case (r_state)
      AG: begin
        w_load = w_done;
        if (AS && !BS) begin
          w_next_state = AG;
          w_load_val   = D_AG;
        end else begin
          w_next_state = w_done ? AY : AG;
          w_load_val   = D_AY;
        end
      end
      AY: begin
        w_load = w_done;
`ifdef ALL_RED_EN
        w_next_state = w_done ? ACLR : AY;
        w_load_val   = CNT_W'(T_AR);
`else
        w_next_state = w_done ? BG : AY;
        w_load_val   = D_BG;
`endif
      end
`ifdef ALL_RED_EN
      ACLR: begin
        w_load       = w_done;
        w_next_state = w_done ? BG : ACLR;
        w_load_val   = D_BG;
      end
`endif
      BG: begin
        w_load = w_done;
        if (BS && !AS) begin
          w_next_state = BG;
          w_load_val   = D_BG;
        end else begin
          w_next_state = w_done ? BY : BG;
          w_load_val   = D_BY;
        end
      end
      BY: begin
        w_load = w_done;
`ifdef ALL_RED_EN
        w_next_state = w_done ? BCLR : BY;
        w_load_val   = CNT_W'(T_AR);
`else
        w_next_state = w_done ? AG : BY;
        w_load_val   = D_AG;
`endif
      end
`ifdef ALL_RED_EN
      BCLR: begin
        w_load       = w_done;
        w_next_state = w_done ? AG : BCLR;
        w_load_val   = D_AG;
      end
`endif
      default: begin
        w_next_state = AG;
        w_load       = 1'b1;
        w_load_val   = D_AG;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= AG;
    end else begin
      r_state <= w_next_state;
    end
  end

  assign state = r_state;

  // Lamps and countdowns follow the registered phase and counter directly.
  always_comb begin
    led    = '0;
    A_time = w_cnt;
    B_time = w_cnt;
    case (r_state)
      AG: begin
        led[LED_A_GRN] = 1'b1;
        led[LED_B_RED] = 1'b1;
        B_time         = w_cnt + CNT_W'(T_AY + C_CLR);
      end
      AY: begin
        led[LED_A_YEL] = 1'b1;
        led[LED_B_RED] = 1'b1;
        B_time         = w_cnt + CNT_W'(C_CLR);
      end
`ifdef ALL_RED_EN
      ACLR: begin
        led[LED_A_RED]   = 1'b1;
        led[LED_B_RED]   = 1'b1;
        led[LED_ALL_RED] = 1'b1;
        A_time           = w_cnt + CNT_W'(T_BG + T_BY + C_CLR);
      end
`endif
      BG: begin
        led[LED_A_RED] = 1'b1;
        led[LED_B_GRN] = 1'b1;
        A_time         = w_cnt + CNT_W'(T_BY + C_CLR);
      end
      BY: begin
        led[LED_A_RED] = 1'b1;
        led[LED_B_YEL] = 1'b1;
        A_time         = w_cnt + CNT_W'(C_CLR);
      end
`ifdef ALL_RED_EN
      BCLR: begin
        led[LED_A_RED]   = 1'b1;
        led[LED_B_RED]   = 1'b1;
        led[LED_ALL_RED] = 1'b1;
        B_time           = w_cnt + CNT_W'(T_AG + T_AY + C_CLR);
      end
`endif
      default: begin
        led[LED_A_RED] = 1'b1;
        led[LED_B_RED] = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: table of tick runs with hand-derived expected outputs,
// plus async reset mid-phase and illegal-state recovery sequences.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

`ifdef ALL_RED_EN
  localparam int unsigned C = 2;
`else
  localparam int unsigned C = 0;
`endif

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       AS = 1'b0;
  logic       BS = 1'b0;
  logic [2:0] state;
  logic [6:0] led;
  logic [5:0] A_time;
  logic [5:0] B_time;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int unsigned ticks;
    int unsigned gap;
    bit          as;
    bit          bs;
    logic [2:0]  st;
    logic [6:0]  led;
    logic [5:0]  a;
    logic [5:0]  b;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  traffic_phase_ctrl dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .tick_1hz (tick_1hz),
    .AS       (AS),
    .BS       (BS),
    .state    (state),
    .led      (led),
    .A_time   (A_time),
    .B_time   (B_time)
  );

  always #10 CLK = ~CLK;

  function automatic void add(int unsigned t, int unsigned g, bit as, bit bs,
                              logic [2:0] st, logic [6:0] l, int unsigned a, int unsigned b);
    vec_t v;
    v.ticks = t; v.gap = g; v.as = as; v.bs = bs;
    v.st = st; v.led = l; v.a = 6'(a); v.b = 6'(b);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Ticks are one cycle wide; idle gap cycles carry random sensor values.
  task automatic do_ticks(input int unsigned n, input int unsigned gap, input bit as, input bit bs);
    for (int i = 0; i < int'(n); i++) begin
      for (int g = 0; g < int'(gap); g++) begin
        @(negedge CLK);
        tick_1hz = 1'b0;
        AS = 1'($urandom);
        BS = 1'($urandom);
      end
      @(negedge CLK);
      tick_1hz = 1'b1;
      AS = as;
      BS = bs;
    end
    @(negedge CLK);
    tick_1hz = 1'b0;
  endtask

  initial begin
    vec_t v;

    add(0, 0, 0, 0, 3'd0, 7'b0011000, 30, 35 + C);
    add(1, 2, 0, 0, 3'd0, 7'b0011000, 29, 34 + C);
    add(28, 0, 0, 0, 3'd0, 7'b0011000, 1, 6 + C);
    add(1, 1, 0, 0, 3'd1, 7'b0101000, 5, 5 + C);
    add(4, 3, 0, 0, 3'd1, 7'b0101000, 1, 1 + C);
`ifdef ALL_RED_EN
    add(1, 0, 0, 0, 3'd2, 7'b1001001, 29, 2);
    add(1, 0, 0, 0, 3'd2, 7'b1001001, 28, 1);
`endif
    add(1, 0, 0, 0, 3'd3, 7'b1000010, 25 + C, 20);
    add(19, 1, 1, 1, 3'd3, 7'b1000010, 6 + C, 1);
    add(1, 0, 0, 1, 3'd3, 7'b1000010, 25 + C, 20);
    add(19, 0, 0, 1, 3'd3, 7'b1000010, 6 + C, 1);
    add(1, 0, 1, 1, 3'd4, 7'b1000100, 5 + C, 5);
    add(2, 0, 0, 0, 3'd4, 7'b1000100, 3 + C, 3);
    add(2, 0, 0, 0, 3'd4, 7'b1000100, 1 + C, 1);
`ifdef ALL_RED_EN
    add(1, 0, 0, 0, 3'd5, 7'b1001001, 2, 39);
    add(1, 0, 0, 0, 3'd5, 7'b1001001, 1, 38);
`endif
    add(1, 0, 0, 0, 3'd0, 7'b0011000, 30, 35 + C);
    add(29, 1, 0, 1, 3'd0, 7'b0011000, 1, 6 + C);
    add(1, 0, 1, 0, 3'd0, 7'b0011000, 30, 35 + C);
    add(29, 0, 1, 0, 3'd0, 7'b0011000, 1, 6 + C);
    add(1, 2, 1, 0, 3'd0, 7'b0011000, 30, 35 + C);
    add(29, 0, 1, 1, 3'd0, 7'b0011000, 1, 6 + C);
    add(1, 0, 1, 1, 3'd1, 7'b0101000, 5, 5 + C);

    repeat (3) @(negedge CLK);
    RSTn = 1'b1;

    foreach (vecs[i]) begin
      sb.push_back(vecs[i]);
      do_ticks(vecs[i].ticks, vecs[i].gap, vecs[i].as, vecs[i].bs);
      #1;
      v = sb.pop_front();
      chk($sformatf("row%0d state", i), state, v.st);
      chk($sformatf("row%0d led", i), led, v.led);
      chk($sformatf("row%0d A_time", i), A_time, v.a);
      chk($sformatf("row%0d B_time", i), B_time, v.b);
    end

    // Fresh reset, run into BY with three seconds left, then reset between clock edges.
    @(negedge CLK);
    RSTn = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    AS = 1'b0;
    BS = 1'b0;
    do_ticks(30, 0, 0, 0);
    do_ticks(5, 0, 0, 0);
`ifdef ALL_RED_EN
    do_ticks(2, 0, 0, 0);
`endif
    do_ticks(20, 0, 0, 0);
    do_ticks(2, 0, 0, 0);
    #1;
    chk("pre_rst state", state, 4);
    chk("pre_rst B_time", B_time, 3);
    #1;
    RSTn = 1'b0;
    #1;
    chk("async_rst state", state, 0);
    chk("async_rst led", led, 7'b0011000);
    chk("async_rst A_time", A_time, 30);
    chk("async_rst B_time", B_time, 35 + C);
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    chk("post_rst idle A_time", A_time, 30);
    do_ticks(1, 0, 0, 0);
    #1;
    chk("post_rst tick A_time", A_time, 29);

    // Illegal code 7 recovers to AG with a fresh green on the next edge, no tick needed.
    @(negedge CLK);
    force dut.r_state = phase_e'(3'd7);
    #1;
    release dut.r_state;
    @(posedge CLK);
    #1;
    chk("illegal state", state, 0);
    chk("illegal A_time", A_time, 30);
    chk("illegal led", led, 7'b0011000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
